sha_nonce_ctrl: RTL
===================

# sha_nonce_ctrl

Sequencer that drives `sha_core` through a nonce search. It generates the `loadEn` and `cycle` controls and the current `nonce`, and samples the core's `first32` at the end of every 64-cycle hash. It reports either the first nonce that meets the difficulty or that the requested range is exhausted. It sits between the host/command interface and `sha_core`; `midState` and `headData` are wired to the core directly, not through this block.

## Interface
- `DIFF_BITS`, default 32: number of upper bits of `first32` that must be zero for a hit. Legal range 1..32.
- `clk`  in  1: system clock, rising-edge.
- `n_rst`  in  1: asynchronous active-low reset.
- `start`  in  1: begin a search. Sampled only in IDLE.
- `abort`  in  1: synchronous cancel, honoured in any state.
- `startNonce`  in  32: first nonce of the range. Captured when `start` is accepted.
- `endNonce`  in  32: last nonce of the range, inclusive. Captured when `start` is accepted.
- `first32`  in  32: result word from `sha_core`. Valid only while `cycle` == 63.
- `loadEn`  out  1: load pulse to `sha_core`.
- `cycle`  out  6: round counter to `sha_core`.
- `nonce`  out  32: nonce currently being hashed.
- `busy`  out  1: high in LOAD and RUN.
- `done`  out  1: one-cycle pulse on search completion.
- `found`  out  1: last completed search produced a hit.
- `foundNonce`  out  32: nonce of that hit.
- `attempts`  out  32: nonces fully evaluated in the current or last search.

## Operation
- States: IDLE, LOAD, RUN, DONE. Registered state.
- Reset values: state IDLE, with every output 0 — `loadEn`, `cycle`, `nonce`, `busy`, `done`, `found`, `foundNonce`, `attempts`.
- IDLE: outputs hold. On `start`=1:
  - capture `startNonce` and `endNonce`;
  - `nonce` <= `startNonce`, `cycle` <= 0;
  - `found` <= 0, `foundNonce` <= 0, `attempts` <= 0;
  - go to LOAD.
- LOAD: exactly one cycle; `loadEn`=1, `cycle`=0. Unconditionally go to RUN; `cycle` stays 0.
- RUN: `loadEn`=0; `cycle` increments by 1 each clock.
- At the edge where `cycle` == 63, evaluate the hit condition: `first32[31:32-DIFF_BITS]` all zero. Then `attempts` <= `attempts`+1, and take the first matching branch:
  - hit: `found` <= 1, `foundNonce` <= `nonce`, go to DONE.
  - miss and `nonce` == captured end: go to DONE with `found`=0.
  - otherwise: `nonce` <= `nonce`+1 (mod 2^32), `cycle` <= 0 (natural wrap), stay in RUN. No LOAD is needed; the core reloads at `cycle` == 0.
- DONE: `done`=1 for one cycle, `cycle` <= 0, then go to IDLE. `found`, `foundNonce`, `attempts` and `nonce` hold until the next accepted `start`.
- `abort`=1 in LOAD, RUN or DONE: next state IDLE, `cycle` <= 0, `loadEn` <= 0, no `done` pulse. `found`, `foundNonce` and `attempts` keep their current values. `abort` has priority over `start` and over the cycle-63 evaluation.
- `start` while not in IDLE is ignored. `start` and `abort` both high in IDLE: `abort` wins, stay in IDLE.
- Range wrap: if end < start, counting passes 0xFFFFFFFF -> 0x00000000 and stops at equality.
  - `startNonce` == `endNonce` searches exactly one nonce.
  - `endNonce` == `startNonce`-1 covers all 2^32 nonces; `attempts` wraps to 0 in that case.
- Input changes to `startNonce` and `endNonce` after capture have no effect.

## Timing
- `start` sampled at edge E0 -> LOAD during (E0,E1], RUN with `cycle`=0 after E1.
- `cycle` == 63 during (E64,E65]. The first nonce is evaluated at E65.
- Hash throughput: 64 clocks per nonce, back-to-back, no bubble between nonces.
- Hit on the k-th nonce (k starting at 1): DONE and `done`=1 during (E(1+64k), E(2+64k)]; IDLE after that.
- Miss on all N nonces: `done` during (E(1+64N), E(2+64N)].
- `busy` falls in the same cycle `done` rises. A new `start` is accepted at the first edge after DONE.
- `n_rst` low mid-search: immediate asynchronous return to reset values. No `done` pulse.

## Test plan
- Reset: hold `n_rst`=0 with `start`=1 -> all outputs 0, `busy`=0; release -> still IDLE until `start` is sampled.
- Hit mid-range: `startNonce`=0x3, `endNonce`=0x10, `DIFF_BITS`=32. Bench model returns `first32`=0 only for `nonce`=0x5 at `cycle`=63, else 0xFFFFFFFF.
  - `done` pulses at E193, `found`=1, `foundNonce`=0x5, `attempts`=3.
  - `loadEn` is high only during (E0,E1].
- Exhaust: `startNonce`=0x7, `endNonce`=0x8, model always misses -> `done` at E129, `found`=0, `attempts`=2, `nonce`=0x8.
- Wrap: `startNonce`=0xFFFFFFFE, `endNonce`=0x1, hit only on 0x0 -> `nonce` sequence FFFFFFFE, FFFFFFFF, 0 -> `foundNonce`=0x0, `attempts`=3.
- Difficulty: `DIFF_BITS`=8, model returns 0x00FFFFFF on the first nonce -> hit. Returning 0x01000000 instead -> miss.
- Abort/reset: assert `abort` at `cycle`=20 of the second nonce -> IDLE next edge, no `done`, `attempts`=1. Repeat the run with `n_rst` pulsed instead of `abort` -> all outputs 0. In both cases a fresh `start` runs normally.

Source files
------------

// File: rtl/sha_nonce_ctrl.sv
// -----------------------------------------------------------------------------
// sha_nonce_ctrl
//
// Sequencer that walks sha_core through a nonce range. Each nonce takes
// exactly 64 clocks (cycle 0..63). The result word first32 is sampled at the
// edge that ends cycle 63; the search stops on the first hit (upper DIFF_BITS
// of first32 all zero) or once the captured end nonce has been evaluated.
//
// Ports
//   clk         in   system clock, rising edge
//   n_rst       in   asynchronous active-low reset
//   start       in   begin a search (only looked at in IDLE)
//   abort       in   synchronous cancel, any state, beats start
//   startNonce  in   first nonce of the range, captured on accepted start
//   endNonce    in   last nonce of the range (inclusive), captured likewise
//   first32     in   sha_core result word, meaningful while cycle == 63
//   loadEn      out  load pulse to sha_core (LOAD state)
//   cycle       out  round counter to sha_core
//   nonce       out  nonce currently being hashed
//   busy        out  high in LOAD and RUN
//   done        out  one-cycle completion pulse (DONE state)
//   found       out  last completed search hit the difficulty target
//   foundNonce  out  nonce of that hit
//   attempts    out  nonces fully evaluated in the current/last search
//   state_dbg   out  current FSM state (IDLE=0, LOAD=1, RUN=2, DONE=3)
//
// Command protocol: start is a level request; it is accepted at any rising
// edge where the FSM is in IDLE, abort is low and start is high. Completion
// is signalled by the single-cycle done pulse; an aborted or reset search
// never pulses done. There is no backpressure.
// -----------------------------------------------------------------------------
module sha_nonce_ctrl #(
  parameter int DIFF_BITS = 32
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] startNonce,
  input  logic [31:0] endNonce,
  input  logic [31:0] first32,
  output logic        loadEn,
  output logic [5:0]  cycle,
  output logic [31:0] nonce,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic [31:0] foundNonce,
  output logic [31:0] attempts,
  output logic [1:0]  state_dbg
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Ones in the upper DIFF_BITS positions. A logical right shift by 32
  // yields zero, so DIFF_BITS == 32 gives an all-ones mask.
  localparam logic [31:0] HIT_MASK = ~(32'hFFFF_FFFF >> DIFF_BITS);

  logic [1:0]  state;
  logic [31:0] end_q;
  logic        hit;

  assign hit = ((first32 & HIT_MASK) == 32'd0);

  // Status strobes decode straight from the registered state, so they are
  // zero in reset and busy drops in the very cycle done rises.
  assign loadEn    = (state == S_LOAD);
  assign busy      = (state == S_LOAD) || (state == S_RUN);
  assign done      = (state == S_DONE);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= S_IDLE;
      cycle      <= 6'd0;
      nonce      <= 32'd0;
      end_q      <= 32'd0;
      found      <= 1'b0;
      foundNonce <= 32'd0;
      attempts   <= 32'd0;
    end else if (abort) begin
      // Results of the interrupted search are left as they are.
      state <= S_IDLE;
      cycle <= 6'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            end_q      <= endNonce;
            nonce      <= startNonce;
            cycle      <= 6'd0;
            found      <= 1'b0;
            foundNonce <= 32'd0;
            attempts   <= 32'd0;
            state      <= S_LOAD;
          end
        end
        S_LOAD: begin
          cycle <= 6'd0;
          state <= S_RUN;
        end
        S_RUN: begin
          // 63 -> 0 wraps naturally; the core reloads itself at cycle 0, so
          // consecutive nonces run back-to-back without another LOAD.
          cycle <= cycle + 6'd1;
          if (cycle == 6'd63) begin
            attempts <= attempts + 32'd1;
            if (hit) begin
              found      <= 1'b1;
              foundNonce <= nonce;
              state      <= S_DONE;
            end else if (nonce == end_q) begin
              state <= S_DONE;
            end else begin
              // Equality stop means a range with end < start simply rolls
              // through 0xFFFFFFFF -> 0.
              nonce <= nonce + 32'd1;
            end
          end
        end
        default: begin // S_DONE
          cycle <= 6'd0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
